// File: rtl/sd_record_loader.sv
// Loads one fixed-size record from a raw SD image via a level-held sector reader,
// validating a header sector first and streaming record bytes out as packed words.
module sd_record_loader #(
   parameter logic [31:0] MAGIC       = 32'h2043_5053,
   parameter int unsigned META_SECTOR = 0,
   parameter int unsigned REC_SECTORS = 129,
   parameter int unsigned REC_BYTES   = 66048,
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned OUT_BYTES   = 1,
   parameter int unsigned TIMEOUT     = 24_750_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [15:0]            num,
   input  logic                   sink_ready,
   output logic [15:0]            total,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [1:0]             fail_code,
   output logic [8*OUT_BYTES-1:0] dout,
   output logic [ADDR_W-1:0]      addr,
   output logic                   dout_valid,
   output logic                   rd_start,
   output logic [31:0]            rd_sector,
   input  logic                   rd_done,
   input  logic                   rd_outen,
   input  logic [7:0]             rd_outbyte
);

   // Byte counter must reach REC_BYTES itself, one past the last address.
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REC_BYTES);
   localparam logic [CNT_W-1:0] LANES    = CNT_W'(OUT_BYTES);
   localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, META, CHECK, WAIT_SINK, READ, GAP, DRAIN, FINISH
   } state_t;

   state_t                      state, state_n;
   logic [15:0]                 num_q, num_n, total_n;
   logic [31:0]                 magic, magic_n, rd_sector_n;
   logic [2:0]                  meta_idx, meta_idx_n;
   logic [CNT_W-1:0]            cnt, cnt_n, lane;
   logic [OUT_BYTES-1:0][7:0]   word, word_n;
   logic [TMO_W-1:0]            tmo, tmo_n;
   logic                        busy_n, done_n, fail_n, dv_n, rd_start_n;
   logic [1:0]                  code_n;
   logic [8*OUT_BYTES-1:0]      dout_n;
   logic [ADDR_W-1:0]           addr_n;
   logic                        tmo_hit, take;

   assign tmo_hit = rd_start && !rd_outen && !rd_done && (tmo == TMO_LIM);
   assign lane    = cnt % LANES;
   assign take    = rd_outen && (cnt < LAST_CNT);

   always_comb begin
      state_n     = state;
      num_n       = num_q;
      total_n     = total;
      magic_n     = magic;
      meta_idx_n  = meta_idx;
      cnt_n       = cnt;
      word_n      = word;
      busy_n      = busy;
      done_n      = done;
      fail_n      = fail;
      code_n      = fail_code;
      dout_n      = dout;
      addr_n      = addr;
      dv_n        = 1'b0;
      rd_start_n  = rd_start;
      rd_sector_n = rd_sector;
      // Idle gap between sectors also restarts the count on every new read.
      tmo_n = (!rd_start || rd_outen || rd_done) ? '0 : tmo + 1'b1;

      case (state)
         IDLE: begin
            if (start && !abort) begin
               done_n      = 1'b0;
               fail_n      = 1'b0;
               code_n      = 2'd0;
               num_n       = num;
               busy_n      = 1'b1;
               magic_n     = '0;
               meta_idx_n  = '0;
               rd_sector_n = 32'(META_SECTOR);
               rd_start_n  = 1'b1;
               state_n     = META;
            end
         end

         META: begin
            if (rd_outen && meta_idx < 3'd6) begin
               meta_idx_n = meta_idx + 3'd1;
               if (meta_idx < 3'd4) magic_n[8*meta_idx +: 8] = rd_outbyte;
               else                 total_n[8*meta_idx[0] +: 8] = rd_outbyte;
            end
            if (abort && rd_done) begin
               busy_n     = 1'b0;
               rd_start_n = 1'b0;
               state_n    = IDLE;
            end else if (abort) begin
               state_n = DRAIN;
            end else if (rd_done) begin
               rd_start_n = 1'b0;
               state_n    = CHECK;
            end else if (tmo_hit) begin
               fail_n     = 1'b1;
               code_n     = 2'd3;
               busy_n     = 1'b0;
               rd_start_n = 1'b0;
               state_n    = IDLE;
            end
         end

         CHECK: begin
            if (abort) begin
               busy_n  = 1'b0;
               state_n = IDLE;
            end else if (magic != MAGIC) begin
               fail_n  = 1'b1;
               code_n  = 2'd1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else if (num_q >= total) begin
               fail_n  = 1'b1;
               code_n  = 2'd2;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               rd_sector_n = 32'(META_SECTOR) + 32'd1 + 32'(num_q) * 32'(REC_SECTORS);
               cnt_n       = '0;
               word_n      = '0;
               state_n     = WAIT_SINK;
            end
         end

         WAIT_SINK: begin
            if (abort) begin
               busy_n  = 1'b0;
               state_n = IDLE;
            end else if (sink_ready) begin
               rd_start_n = 1'b1;
               state_n    = READ;
            end
         end

         READ: begin
            if (abort) begin
               if (rd_done) begin
                  busy_n     = 1'b0;
                  rd_start_n = 1'b0;
                  state_n    = IDLE;
               end else begin
                  state_n = DRAIN;
               end
            end else begin
               if (take) begin
                  for (int i = 0; i < OUT_BYTES; i++)
                     if (lane == CNT_W'(i)) word_n[i] = rd_outbyte;
                  cnt_n = cnt + 1'b1;
                  // A short final word goes out with its unfilled upper lanes zeroed.
                  if (lane == LANES - 1'b1 || cnt + 1'b1 == LAST_CNT) begin
                     dv_n   = 1'b1;
                     dout_n = word_n;
                     addr_n = ADDR_W'(cnt - lane);
                     word_n = '0;
                  end
               end
               if (rd_done) begin
                  rd_start_n = 1'b0;
                  if (cnt_n == LAST_CNT) begin
                     state_n = FINISH;
                  end else begin
                     rd_sector_n = rd_sector + 32'd1;
                     state_n     = GAP;
                  end
               end else if (tmo_hit) begin
                  fail_n     = 1'b1;
                  code_n     = 2'd3;
                  busy_n     = 1'b0;
                  rd_start_n = 1'b0;
                  state_n    = IDLE;
               end
            end
         end

         GAP: begin
            if (abort) begin
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               state_n = WAIT_SINK;
            end
         end

         DRAIN: begin
            if (rd_done || tmo_hit) begin
               busy_n     = 1'b0;
               rd_start_n = 1'b0;
               state_n    = IDLE;
            end
         end

         FINISH: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         num_q      <= '0;
         total      <= '0;
         magic      <= '0;
         meta_idx   <= '0;
         cnt        <= '0;
         word       <= '0;
         tmo        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         fail_code  <= 2'd0;
         dout       <= '0;
         addr       <= '0;
         dout_valid <= 1'b0;
         rd_start   <= 1'b0;
         rd_sector  <= '0;
      end else begin
         state      <= state_n;
         num_q      <= num_n;
         total      <= total_n;
         magic      <= magic_n;
         meta_idx   <= meta_idx_n;
         cnt        <= cnt_n;
         word       <= word_n;
         tmo        <= tmo_n;
         busy       <= busy_n;
         done       <= done_n;
         fail       <= fail_n;
         fail_code  <= code_n;
         dout       <= dout_n;
         addr       <= addr_n;
         dout_valid <= dv_n;
         rd_start   <= rd_start_n;
         rd_sector  <= rd_sector_n;
      end
   end

endmodule
